multi_channel_driver: RTL and testbench



---
 rtl/multi_channel_driver.sv | 149 ++++++++++++++
 tb/tb_multi_channel_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_driver.sv
// Multi-channel H-bridge dot driver: qualified global enable, dead-time insertion
// on turn-on and polarity reversal, and a per-channel on-time watchdog with latched fault.
module multi_channel_driver #(
  parameter int NUM_CHANNELS  = 4,
  parameter int ACTIVE_HOLD   = 4,
  parameter int DEAD_CYCLES   = 2,
  parameter int MAX_ON_CYCLES = 1000,
  parameter int CNT_WIDTH     = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      output_active,
  input  logic [NUM_CHANNELS-1:0]   dot_enable,
  input  logic [NUM_CHANNELS-1:0]   dot_state,
  input  logic [NUM_CHANNELS-1:0]   dot_invert,
  output logic [2*NUM_CHANNELS-1:0] driver_io,
  output logic [NUM_CHANNELS-1:0]   fault,
  output logic                      busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int AW = $clog2(ACTIVE_HOLD + 1);
  localparam logic [AW-1:0]        HOLD    = AW'(ACTIVE_HOLD);
  localparam logic [CNT_WIDTH-1:0] DEAD_LD = CNT_WIDTH'(DEAD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ON_LAST = CNT_WIDTH'((MAX_ON_CYCLES > 0) ? (MAX_ON_CYCLES - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [AW-1:0]           active_cnt_q, active_cnt_d;
  logic                    active_ok;
  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] pol;
  logic [NUM_CHANNELS-1:0] chan_busy;

  // Global qualification: output_active must be held ACTIVE_HOLD cycles
  always_comb begin
    active_cnt_d = active_cnt_q;
    if (!output_active) begin
      active_cnt_d = '0;
    end else if (active_cnt_q != HOLD) begin
      active_cnt_d = active_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_cnt_q <= '0;
    end else begin
      active_cnt_q <= active_cnt_d;
    end
  end

  assign active_ok = (active_cnt_q == HOLD);
  assign req       = dot_enable & {NUM_CHANNELS{active_ok}};
  assign pol       = dot_state ^ dot_invert;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic [1:0]           state_q, state_d;
    logic                 lpol_q, lpol_d;
    logic [CNT_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [CNT_WIDTH-1:0] ocnt_q, ocnt_d;

    always_comb begin
      state_d = state_q;
      lpol_d  = lpol_q;
      dcnt_d  = dcnt_q;
      ocnt_d  = ocnt_q;
      case (state_q)
        ST_IDLE: begin
          if (req[i]) begin
            lpol_d = pol[i];
            if (DEAD_CYCLES == 0) begin
              state_d = ST_DRIVE;
              ocnt_d  = '0;
            end else begin
              state_d = ST_DEAD;
              dcnt_d  = DEAD_LD;
            end
          end
        end
        ST_DEAD: begin
          if (!req[i]) begin
            state_d = ST_IDLE;
          end else if (pol[i] != lpol_q) begin
            // A reversal while waiting restarts the full dead interval
            dcnt_d = DEAD_LD;
            lpol_d = pol[i];
          end else if (dcnt_q == CNT_ONE) begin
            state_d = ST_DRIVE;
            ocnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q - CNT_ONE;
          end
        end
        ST_DRIVE: begin
          if (!req[i]) begin
            state_d = ST_IDLE;
          end else if (pol[i] != lpol_q) begin
            lpol_d = pol[i];
            if (DEAD_CYCLES == 0) begin
              ocnt_d = '0;
            end else begin
              state_d = ST_DEAD;
              dcnt_d  = DEAD_LD;
            end
          end else if ((MAX_ON_CYCLES != 0) && (ocnt_q == ON_LAST)) begin
            state_d = ST_FAULT;
          end else begin
            ocnt_d = ocnt_q + CNT_ONE;
          end
        end
        ST_FAULT: begin
          // Only a released request clears the fault, never output_active
          if (!dot_enable[i]) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= ST_IDLE;
        lpol_q  <= 1'b0;
        dcnt_q  <= '0;
        ocnt_q  <= '0;
      end else begin
        state_q <= state_d;
        lpol_q  <= lpol_d;
        dcnt_q  <= dcnt_d;
        ocnt_q  <= ocnt_d;
      end
    end

    assign driver_io[2*i+1] = (state_q == ST_DRIVE) &&  lpol_q;
    assign driver_io[2*i]   = (state_q == ST_DRIVE) && !lpol_q;
    assign fault[i]         = (state_q == ST_FAULT);
    assign chan_busy[i]     = (state_q != ST_IDLE);
  end

  assign busy = |chan_busy;

endmodule

// File: tb/tb_multi_channel_driver.sv
// Scoreboard bench for multi_channel_driver: a reference model predicts each cycle's
// outputs, and directed checks pin down the key timing points.
module tb_multi_channel_driver;
  localparam int NC  = 4;
  localparam int AH  = 4;
  localparam int DC  = 2;
  localparam int MAX = 8;

  localparam logic [1:0] M_IDLE = 2'd0, M_DEAD = 2'd1, M_DRIVE = 2'd2, M_FAULT = 2'd3;

  logic            clock = 1'b0;
  logic            reset;
  logic            output_active;
  logic [NC-1:0]   dot_enable, dot_state, dot_invert;
  logic [2*NC-1:0] driver_io;
  logic [NC-1:0]   fault;
  logic            busy;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [2*NC-1:0] io;
    logic [NC-1:0]   flt;
    logic            bsy;
  } exp_t;
  exp_t sb_q[$];

  int       m_act;
  logic [1:0] m_st [NC];
  bit       m_lpol [NC];
  int       m_dcnt [NC];
  int       m_ocnt [NC];

  multi_channel_driver #(
    .NUM_CHANNELS (NC),
    .ACTIVE_HOLD  (AH),
    .DEAD_CYCLES  (DC),
    .MAX_ON_CYCLES(MAX),
    .CNT_WIDTH    (10)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .output_active(output_active),
    .dot_enable   (dot_enable),
    .dot_state    (dot_state),
    .dot_invert   (dot_invert),
    .driver_io    (driver_io),
    .fault        (fault),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: advance one clock edge using the inputs as currently driven
  task automatic model_edge();
    bit ok, req, pol;
    if (reset) begin
      m_act = 0;
      for (int i = 0; i < NC; i++) begin
        m_st[i] = M_IDLE; m_lpol[i] = 0; m_dcnt[i] = 0; m_ocnt[i] = 0;
      end
      return;
    end
    ok = (m_act == AH);
    if (!output_active) m_act = 0;
    else if (m_act < AH) m_act = m_act + 1;
    for (int i = 0; i < NC; i++) begin
      req = dot_enable[i] && ok;
      pol = dot_state[i] ^ dot_invert[i];
      case (m_st[i])
        M_IDLE:
          if (req) begin m_lpol[i] = pol; m_st[i] = M_DEAD; m_dcnt[i] = DC; end
        M_DEAD:
          if (!req) m_st[i] = M_IDLE;
          else if (pol != m_lpol[i]) begin m_lpol[i] = pol; m_dcnt[i] = DC; end
          else if (m_dcnt[i] == 1) begin m_st[i] = M_DRIVE; m_ocnt[i] = 0; end
          else m_dcnt[i]--;
        M_DRIVE:
          if (!req) m_st[i] = M_IDLE;
          else if (pol != m_lpol[i]) begin m_lpol[i] = pol; m_st[i] = M_DEAD; m_dcnt[i] = DC; end
          else if (m_ocnt[i] == MAX - 1) m_st[i] = M_FAULT;
          else m_ocnt[i]++;
        default:
          if (!dot_enable[i]) m_st[i] = M_IDLE;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < NC; i++) begin
      e.io[2*i+1] = (m_st[i] == M_DRIVE) &&  m_lpol[i];
      e.io[2*i]   = (m_st[i] == M_DRIVE) && !m_lpol[i];
      e.flt[i]    = (m_st[i] == M_FAULT);
      if (m_st[i] != M_IDLE) e.bsy = 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    logic [NC-1:0] overlap;
    model_edge();
    sb_q.push_back(model_out());
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk("sb_io", 32'(driver_io), 32'(e.io));
    chk("sb_fault", 32'(fault), 32'(e.flt));
    chk("sb_busy", 32'(busy), 32'(e.bsy));
    for (int i = 0; i < NC; i++) overlap[i] = driver_io[2*i+1] & driver_io[2*i];
    chk("no_shoot_through", 32'(overlap), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int on_cycles;

    // Reset with every input high
    reset = 1'b1; output_active = 1'b1;
    dot_enable = '1; dot_state = '1; dot_invert = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_io", 32'(driver_io), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    reset = 1'b0;
    step();
    chk("rel_io", 32'(driver_io), 0);
    chk("rel_busy", 32'(busy), 0);

    // Turn-on with default dead time, both polarity encodings
    output_active = 1'b0; dot_enable = '0; dot_state = '0; dot_invert = '0;
    step();
    output_active = 1'b1;
    repeat (4) step();
    dot_enable[0] = 1'b1; dot_state[0] = 1'b1;
    step(); chk("on_k1", 32'(driver_io[1:0]), 2'b00);
    step(); chk("on_k2", 32'(driver_io[1:0]), 2'b00);
    step(); chk("on_k3", 32'(driver_io[1:0]), 2'b10);
    step(); chk("on_k4", 32'(driver_io[1:0]), 2'b10);
    dot_enable[0] = 1'b0;
    step(); chk("off_k1", 32'(driver_io[1:0]), 2'b00);
    dot_enable[0] = 1'b1; dot_invert[0] = 1'b1;
    repeat (2) step();
    chk("inv_dead", 32'(driver_io[1:0]), 2'b00);
    step(); chk("inv_on", 32'(driver_io[1:0]), 2'b01);
    dot_enable[0] = 1'b0; dot_invert[0] = 1'b0; dot_state[0] = 1'b0;
    step();

    // Polarity reversal on channel 1
    dot_enable[1] = 1'b1; dot_state[1] = 1'b1;
    repeat (3) step();
    chk("rev_pre", 32'(driver_io[3:2]), 2'b10);
    dot_state[1] = 1'b0;
    step(); chk("rev_k1", 32'(driver_io[3:2]), 2'b00);
    step(); chk("rev_k2", 32'(driver_io[3:2]), 2'b00);
    step(); chk("rev_k3", 32'(driver_io[3:2]), 2'b01);
    dot_enable[1] = 1'b0;
    step();

    // Watchdog on channel 2
    dot_enable[2] = 1'b1;
    on_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (driver_io[5:4] != 2'b00) on_cycles++;
      if (fault[2]) break;
    end
    chk("wd_on_cycles", 32'(on_cycles), MAX);
    chk("wd_fault", 32'(fault[2]), 1);
    chk("wd_pins", 32'(driver_io[5:4]), 2'b00);
    repeat (3) step();
    chk("wd_hold", 32'(fault[2]), 1);
    dot_enable[2] = 1'b0;
    step(); chk("wd_clear", 32'(fault[2]), 0);
    dot_enable[2] = 1'b1;
    step(); chk("wd_rearm_d1", 32'(driver_io[5:4]), 2'b00);
    step(); chk("wd_rearm_d2", 32'(driver_io[5:4]), 2'b00);
    step(); chk("wd_rearm_on", 32'(driver_io[5:4]), 2'b01);
    dot_enable[2] = 1'b0;
    step();

    // Global gating and re-qualification
    dot_enable = '1; dot_state = 4'b0101;
    repeat (3) step();
    chk("all_drive", 32'(driver_io), 8'h66);
    output_active = 1'b0;
    step(); chk("gate_k1", 32'(driver_io), 8'h66);
    step(); chk("gate_k2", 32'(driver_io), 0);
    output_active = 1'b1;
    repeat (3) step();
    chk("hold3_busy", 32'(busy), 0);
    output_active = 1'b0;
    step();
    output_active = 1'b1;
    repeat (4) step();
    chk("hold4_idle", 32'(busy), 0);
    step(); chk("hold4_honoured", 32'(busy), 1);
    repeat (2) step();
    chk("requal_drive", 32'(driver_io), 8'h66);
    dot_enable = '0;
    step();

    // Abort during dead time on channel 3
    dot_enable[3] = 1'b1;
    step(); chk("abort_d1", 32'(driver_io[7:6]), 2'b00);
    step(); chk("abort_d2", 32'(driver_io[7:6]), 2'b00);
    dot_enable[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_pins", 32'(driver_io[7:6]), 2'b00);
    end
    chk("abort_busy", 32'(busy), 0);

    // Reset while driving
    dot_enable[0] = 1'b1; dot_state[0] = 1'b1;
    repeat (3) step();
    chk("pre_rst_drive", 32'(driver_io[1:0]), 2'b10);
    reset = 1'b1;
    step();
    chk("mid_rst_io", 32'(driver_io), 0);
    chk("mid_rst_fault", 32'(fault), 0);
    reset = 1'b0; dot_enable = '0;
    step();

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
